// File: rtl/calc_op_sequencer.sv
// Enter-button conditioner and command queue for the accumulator calculator.
// Debounced presses queue {op, operand}; queued commands issue over step/ready.
module calc_op_sequencer #(
  parameter int NUM_WIDTH       = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clock,
  input  logic                          Reset,
  input  logic [NUM_WIDTH-1:0]          NumIn,
  input  logic [1:0]                    OpIn,
  input  logic                          Enter,
  input  logic                          Clear,
  output logic [NUM_WIDTH-1:0]          DpNum,
  output logic [1:0]                    DpOp,
  output logic                          DpStep,
  input  logic                          DpReady,
  output logic [$clog2(FIFO_DEPTH):0]   Pending,
  output logic                          Busy,
  output logic                          Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int EW = NUM_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   head;
  logic            press, full, pop, do_push;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    press = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
        press = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A pop on the same edge frees the slot a full-queue push needs.
  assign full    = count_q == (AW+1)'(FIFO_DEPTH);
  assign pop     = (state_q == ISSUE) && DpReady;
  assign do_push = press && (!full || pop) && !Clear;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q | (press && full && !pop);
    state_d = state_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (pop)     rd_d = rd_q + 1'b1;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   if (DpReady) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Clear) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q <= Enter;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      if (do_push) mem_q[wr_q] <= {OpIn, NumIn};
    end
  end

  assign head     = mem_q[rd_q];
  assign DpStep   = state_q == ISSUE;
  assign DpOp     = DpStep ? head[EW-1 -: 2] : 2'b00;
  assign DpNum    = DpStep ? head[NUM_WIDTH-1:0] : '0;
  assign Pending  = count_q;
  assign Busy     = (state_q != IDLE) || (count_q != '0);
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed presses queue expected
// commands, a negedge monitor checks each accepted issue in order.
module tb_calc_op_sequencer;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] NumIn = '0;
  logic [1:0] OpIn = '0;
  logic       Enter = 1'b0;
  logic       Clear = 1'b0;
  logic [7:0] DpNum;
  logic [1:0] DpOp;
  logic       DpStep;
  logic       DpReady = 1'b0;
  logic [2:0] Pending;
  logic       Busy;
  logic       Overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int issued = 0;
  int last_acc = -100;
  logic [9:0] exp_q[$];
  logic [9:0] e;

  calc_op_sequencer #(
    .NUM_WIDTH(8),
    .FIFO_DEPTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .NumIn(NumIn),
    .OpIn(OpIn),
    .Enter(Enter),
    .Clear(Clear),
    .DpNum(DpNum),
    .DpOp(DpOp),
    .DpStep(DpStep),
    .DpReady(DpReady),
    .Pending(Pending),
    .Busy(Busy),
    .Overflow(Overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (Reset && DpStep && DpReady) begin
      issued++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue: got %0h expected none",
                 {DpOp, DpNum});
      end else begin
        e = exp_q.pop_front();
        chk("issue_cmd", {22'd0, DpOp, DpNum}, {22'd0, e});
      end
      if (issued > 1)
        chk("issue_spacing", {31'd0, (cyc - last_acc) >= 3}, 32'd1);
      last_acc = cyc;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(logic [1:0] op, logic [7:0] n, bit accept);
    OpIn = op;
    NumIn = n;
    Enter = 1'b1;
    if (accept) exp_q.push_back({op, n});
    tick(8);
    Enter = 1'b0;
    tick(8);
  endtask

  initial begin
    tick(3);
    chk("rst_step", {31'd0, DpStep}, 32'd0);
    chk("rst_num", {24'd0, DpNum}, 32'd0);
    chk("rst_op", {30'd0, DpOp}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_pending", {29'd0, Pending}, 32'd0);
    chk("rst_ovf", {31'd0, Overflow}, 32'd0);
    Reset = 1'b1;
    tick(2);

    // single held press, ready tied high
    DpReady = 1'b1;
    OpIn = 2'b00;
    NumIn = 8'h05;
    Enter = 1'b1;
    exp_q.push_back({2'b00, 8'h05});
    tick(5);
    chk("t1_pend_e4", {29'd0, Pending}, 32'd0);
    tick(1);
    chk("t1_pend_e5", {29'd0, Pending}, 32'd1);
    chk("t1_step_e5", {31'd0, DpStep}, 32'd0);
    tick(1);
    chk("t1_step_e6", {31'd0, DpStep}, 32'd1);
    chk("t1_op_e6", {30'd0, DpOp}, 32'd0);
    chk("t1_num_e6", {24'd0, DpNum}, 32'h05);
    tick(1);
    chk("t1_step_gap", {31'd0, DpStep}, 32'd0);
    chk("t1_num_gap", {24'd0, DpNum}, 32'd0);
    chk("t1_pend_gap", {29'd0, Pending}, 32'd0);
    chk("t1_busy_gap", {31'd0, Busy}, 32'd1);
    tick(1);
    chk("t1_busy_idle", {31'd0, Busy}, 32'd0);
    tick(1);
    Enter = 1'b0;
    tick(10);
    chk("t1_issued", issued, 32'd1);

    // short glitch
    Enter = 1'b1;
    tick(3);
    Enter = 1'b0;
    tick(12);
    chk("t2_pending", {29'd0, Pending}, 32'd0);
    chk("t2_busy", {31'd0, Busy}, 32'd0);
    chk("t2_issued", issued, 32'd1);

    // fill, overflow, drain
    DpReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(2'(i + 1), 8'(i + 1), i < 4);
      if (i == 3) begin
        chk("t3_pend_full", {29'd0, Pending}, 32'd4);
        chk("t3_ovf_full", {31'd0, Overflow}, 32'd0);
      end
    end
    chk("t3_pend_drop", {29'd0, Pending}, 32'd4);
    chk("t3_ovf_drop", {31'd0, Overflow}, 32'd1);
    DpReady = 1'b1;
    tick(20);
    chk("t3_pend_drained", {29'd0, Pending}, 32'd0);
    chk("t3_issued", issued, 32'd5);
    for (int i = 0; i < 3; i++) press(2'(3 - i), 8'hA0 + 8'(i), 1'b1);
    chk("t3_wrap_issued", issued, 32'd8);
    chk("t3_ovf_sticky", {31'd0, Overflow}, 32'd1);
    Clear = 1'b1;
    tick(1);
    Clear = 1'b0;
    chk("t3_ovf_cleared", {31'd0, Overflow}, 32'd0);

    // full queue, push and pop on the same edge
    DpReady = 1'b0;
    for (int i = 0; i < 4; i++) press(2'(i), 8'h11 + 8'(i), 1'b1);
    chk("t4_pend_full", {29'd0, Pending}, 32'd4);
    OpIn = 2'b10;
    NumIn = 8'h55;
    Enter = 1'b1;
    exp_q.push_back({2'b10, 8'h55});
    tick(5);
    DpReady = 1'b1;
    tick(1);
    DpReady = 1'b0;
    chk("t4_pend_same", {29'd0, Pending}, 32'd4);
    chk("t4_ovf_same", {31'd0, Overflow}, 32'd0);
    tick(6);
    Enter = 1'b0;
    tick(8);
    DpReady = 1'b1;
    tick(20);
    chk("t4_pend_drained", {29'd0, Pending}, 32'd0);
    chk("t4_issued", issued, 32'd13);

    // clear while issuing, button still held
    DpReady = 1'b0;
    press(2'b01, 8'h21, 1'b1);
    press(2'b10, 8'h22, 1'b1);
    OpIn = 2'b11;
    NumIn = 8'h23;
    Enter = 1'b1;
    exp_q.push_back({2'b11, 8'h23});
    tick(6);
    chk("t5_pend_pre", {29'd0, Pending}, 32'd3);
    chk("t5_step_pre", {31'd0, DpStep}, 32'd1);
    Clear = 1'b1;
    exp_q.delete();
    tick(1);
    Clear = 1'b0;
    chk("t5_pend_clr", {29'd0, Pending}, 32'd0);
    chk("t5_step_clr", {31'd0, DpStep}, 32'd0);
    chk("t5_ovf_clr", {31'd0, Overflow}, 32'd0);
    chk("t5_busy_clr", {31'd0, Busy}, 32'd0);
    tick(10);
    chk("t5_pend_held", {29'd0, Pending}, 32'd0);
    Enter = 1'b0;
    tick(8);
    chk("t5_pend_rel", {29'd0, Pending}, 32'd0);
    chk("t5_issued", issued, 32'd13);

    // async reset mid-issue
    press(2'b01, 8'h66, 1'b0);
    chk("t6_step_pre", {31'd0, DpStep}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("t6_step_rst", {31'd0, DpStep}, 32'd0);
    chk("t6_num_rst", {24'd0, DpNum}, 32'd0);
    chk("t6_pend_rst", {29'd0, Pending}, 32'd0);
    chk("t6_busy_rst", {31'd0, Busy}, 32'd0);
    tick(2);
    Reset = 1'b1;
    tick(5);
    chk("t6_step_post", {31'd0, DpStep}, 32'd0);
    chk("t6_pend_post", {29'd0, Pending}, 32'd0);
    DpReady = 1'b1;
    press(2'b10, 8'h77, 1'b1);
    tick(5);
    chk("t6_issued", issued, 32'd14);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
